// File: rtl/reg_override_ctrl.sv
// Register with hardware assign/deassign and force/release overrides.
// Force takes precedence over assign, and assign over normal writes. A force can release itself after a set number of cycles.
module reg_override_ctrl #(
   parameter int               WIDTH     = 2,
   parameter int               HOLD_W    = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              asg_req,
   input  logic [WIDTH-1:0]  asg_data,
   input  logic              dasg_req,
   input  logic              frc_req,
   input  logic [WIDTH-1:0]  frc_data,
   input  logic [HOLD_W-1:0] frc_cycles,
   input  logic              rel_req,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  base_q,
   output logic [1:0]        state,
   output logic [HOLD_W-1:0] frc_left,
   output logic              drop_pulse,
   output logic              err_pulse
);

   typedef enum logic [1:0] {
      NORM     = 2'b00,
      ASGN     = 2'b01,
      FRC      = 2'b10,
      FRC_ASGN = 2'b11
   } state_t;

   state_t              state_r, state_s;
   logic [WIDTH-1:0]    asg_val_r, frc_val_r;
   logic                timed_r;
   logic [WIDTH-1:0]    q_s, base_s, asg_val_s, frc_val_s;
   logic [HOLD_W-1:0]   left_s;
   logic                timed_s, drop_s, err_s;
   logic                forced_s, assigned_s, expire_s, release_s, deasg_s, wr_ok_s;
   logic                frc_n_s, asg_n_s;

   assign state = state_r;

   // Next-state, next-value and pulse evaluation for one clock edge
   always_comb begin
      state_s    = state_r;
      base_s     = base_q;
      asg_val_s  = asg_val_r;
      frc_val_s  = frc_val_r;
      left_s     = frc_left;
      timed_s    = timed_r;
      q_s        = q;
      forced_s   = (state_r == FRC) || (state_r == FRC_ASGN);
      assigned_s = (state_r == ASGN) || (state_r == FRC_ASGN);
      expire_s   = timed_r && (frc_left == HOLD_W'(1));
      // frc_req always wins, so a refresh on the expiry edge keeps the force alive
      release_s  = forced_s && !frc_req && (rel_req || expire_s);
      deasg_s    = assigned_s && dasg_req && !asg_req;
      wr_ok_s    = wr_en && (state_r == NORM) && !asg_req && !frc_req;
      frc_n_s    = frc_req || (forced_s && !release_s);
      asg_n_s    = asg_req || (assigned_s && !deasg_s);
      drop_s     = wr_en && !wr_ok_s;
      err_s      = (rel_req && !forced_s) || (dasg_req && !assigned_s) ||
                   (frc_req && rel_req) || (asg_req && dasg_req);

      case ({frc_n_s, asg_n_s})
         2'b00:   state_s = NORM;
         2'b01:   state_s = ASGN;
         2'b10:   state_s = FRC;
         2'b11:   state_s = FRC_ASGN;
         default: state_s = NORM;
      endcase

      // Leaving an override keeps the overriding value as the stored value.
      if (deasg_s) begin
         base_s = asg_val_r;
      end else if (release_s && !assigned_s) begin
         base_s = frc_val_r;
      end else if (wr_ok_s) begin
         base_s = wr_data;
      end else begin
         base_s = base_q;
      end

      if (asg_req) begin
         asg_val_s = asg_data;
      end else begin
         asg_val_s = asg_val_r;
      end

      if (frc_req) begin
         frc_val_s = frc_data;
         left_s    = frc_cycles;
         timed_s   = (frc_cycles != {HOLD_W{1'b0}});
      end else if (!frc_n_s) begin
         frc_val_s = frc_val_r;
         left_s    = {HOLD_W{1'b0}};
         timed_s   = 1'b0;
      end else if (timed_r && (frc_left != {HOLD_W{1'b0}})) begin
         frc_val_s = frc_val_r;
         left_s    = frc_left - HOLD_W'(1);
         timed_s   = timed_r;
      end else begin
         frc_val_s = frc_val_r;
         left_s    = frc_left;
         timed_s   = timed_r;
      end

      if (frc_n_s) begin
         q_s = frc_val_s;
      end else if (asg_n_s) begin
         q_s = asg_val_s;
      end else begin
         q_s = base_s;
      end
   end

   // State and value registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= NORM;
         base_q     <= RESET_VAL;
         asg_val_r  <= RESET_VAL;
         frc_val_r  <= RESET_VAL;
         q          <= RESET_VAL;
         frc_left   <= {HOLD_W{1'b0}};
         timed_r    <= 1'b0;
         drop_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         state_r    <= state_s;
         base_q     <= base_s;
         asg_val_r  <= asg_val_s;
         frc_val_r  <= frc_val_s;
         q          <= q_s;
         frc_left   <= left_s;
         timed_r    <= timed_s;
         drop_pulse <= drop_s;
         err_pulse  <= err_s;
      end
   end

endmodule

// File: tb/tb_reg_override_ctrl.sv
// Bench for reg_override_ctrl: a hand-computed vector table, then random stimulus checked against a reference model.
// The reference model tracks forces by deadline cycle rather than by a countdown.
module tb_reg_override_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, wr_en, asg_req, dasg_req, frc_req, rel_req;
   logic [1:0] wr_data, asg_data, frc_data;
   logic [7:0] frc_cycles;
   logic [1:0] q, base_q, state;
   logic [7:0] frc_left;
   logic       drop_pulse, err_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_override_ctrl #(.WIDTH(2), .HOLD_W(8), .RESET_VAL(2'b00)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .asg_req(asg_req), .asg_data(asg_data), .dasg_req(dasg_req),
      .frc_req(frc_req), .frc_data(frc_data), .frc_cycles(frc_cycles),
      .rel_req(rel_req), .q(q), .base_q(base_q), .state(state),
      .frc_left(frc_left), .drop_pulse(drop_pulse), .err_pulse(err_pulse)
   );

   typedef struct {
      logic       rst_n, wr; logic [1:0] wd;
      logic       asg; logic [1:0] ad; logic dasg;
      logic       frc; logic [1:0] fd; logic [7:0] fc; logic rel;
      logic [1:0] eq, eb, es; logic [7:0] el; logic ed, ee;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic w, input logic [1:0] wd,
                      input logic a, input logic [1:0] ad, input logic d,
                      input logic f, input logic [1:0] fd, input logic [7:0] fc, input logic rl,
                      input logic [1:0] eq, input logic [1:0] eb, input logic [1:0] es,
                      input logic [7:0] el, input logic ed, input logic ee);
      vec_t v;
      v.rst_n = r; v.wr = w; v.wd = wd; v.asg = a; v.ad = ad; v.dasg = d;
      v.frc = f; v.fd = fd; v.fc = fc; v.rel = rl;
      v.eq = eq; v.eb = eb; v.es = es; v.el = el; v.ed = ed; v.ee = ee;
      tv.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] wd,
                        input logic a, input logic [1:0] ad, input logic d,
                        input logic f, input logic [1:0] fd, input logic [7:0] fc, input logic rl);
      rst_n = r; wr_en = w; wr_data = wd; asg_req = a; asg_data = ad; dasg_req = d;
      frc_req = f; frc_data = fd; frc_cycles = fc; rel_req = rl;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input int idx, input logic [1:0] eq, input logic [1:0] eb, input logic [1:0] es,
                            input logic [7:0] el, input logic ed, input logic ee);
      check("q", idx, 32'(q), 32'(eq));
      check("base_q", idx, 32'(base_q), 32'(eb));
      check("state", idx, 32'(state), 32'(es));
      check("frc_left", idx, 32'(frc_left), 32'(el));
      check("drop_pulse", idx, 32'(drop_pulse), 32'(ed));
      check("err_pulse", idx, 32'(err_pulse), 32'(ee));
   endtask

   // Reference model: override flags, held values and an absolute force deadline.
   logic [1:0] m_base, m_av, m_fv, m_q, m_st;
   bit         m_forced, m_assigned, m_timed, m_drop, m_err;
   int         m_dead, m_edge, m_left;

   task automatic model_step(input logic r, input logic w, input logic [1:0] wd,
                             input logic a, input logic [1:0] ad, input logic d,
                             input logic f, input logic [1:0] fd, input logic [7:0] fc, input logic rl);
      bit expire, rel_now, dasg_now, wr_ok, was_assigned;
      if (!r) begin
         m_base = 2'b00; m_av = 2'b00; m_fv = 2'b00;
         m_forced = 1'b0; m_assigned = 1'b0; m_timed = 1'b0;
         m_drop = 1'b0; m_err = 1'b0;
      end else begin
         was_assigned = m_assigned;
         expire   = m_forced && m_timed && (m_edge == m_dead);
         rel_now  = m_forced && !f && (rl || expire);
         dasg_now = m_assigned && d && !a;
         wr_ok    = w && !m_forced && !m_assigned && !a && !f;
         m_drop   = w && !wr_ok;
         m_err    = (rl && !m_forced) || (d && !m_assigned) || (f && rl) || (a && d);
         if (dasg_now) m_base = m_av;
         else if (rel_now && !was_assigned) m_base = m_fv;
         else if (wr_ok) m_base = wd;
         if (a) begin m_av = ad; m_assigned = 1'b1; end
         else if (dasg_now) m_assigned = 1'b0;
         if (f) begin
            m_fv = fd; m_forced = 1'b1; m_timed = (fc != 8'd0); m_dead = m_edge + int'(fc);
         end else if (rel_now) begin
            m_forced = 1'b0; m_timed = 1'b0;
         end
      end
      m_q    = m_forced ? m_fv : (m_assigned ? m_av : m_base);
      m_st   = {m_forced, m_assigned};
      m_left = (m_forced && m_timed) ? (m_dead - m_edge) : 0;
      m_edge++;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = 2'b00; asg_req = 1'b0; asg_data = 2'b00;
      dasg_req = 1'b0; frc_req = 1'b0; frc_data = 2'b00; frc_cycles = 8'd0; rel_req = 1'b0;
      m_edge = 0; m_dead = 0;

      //   rst wr wd    asg ad    dsg frc fd    fc    rel   q     base  state left  dr  er
      add(1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b00,2'b00,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b00,2'b00,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b1,2'b01,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b00,2'b01,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b00,2'b01,8'd0,1'b1,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b01,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b10,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b10,2'b10,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b00,2'b00,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b1,2'b10,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b10,2'b00,2'b01,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b11,8'd0,1'b0, 2'b11,2'b00,2'b11,8'd0,1'b0,1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b00,2'b11,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b1, 2'b10,2'b00,2'b01,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,8'd0,1'b0, 2'b10,2'b10,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b01,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b01,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b11,8'd3,1'b0, 2'b11,2'b01,2'b10,8'd3,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b01,2'b10,8'd2,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b01,2'b10,8'd1,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b11,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b01,8'd0,1'b1, 2'b01,2'b11,2'b10,8'd0,1'b0,1'b1);
      add(1'b1,1'b0,2'b00,1'b1,2'b10,1'b1,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b11,2'b11,8'd0,1'b0,1'b1);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b1, 2'b10,2'b11,2'b01,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,8'd0,1'b0, 2'b10,2'b10,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b1, 2'b10,2'b10,2'b00,8'd0,1'b0,1'b1);
      add(1'b1,1'b0,2'b00,1'b1,2'b01,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b01,2'b10,2'b01,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b11,8'd5,1'b0, 2'b11,2'b10,2'b11,8'd5,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b10,2'b11,8'd4,1'b0,1'b0);
      add(1'b0,1'b1,2'b11,1'b0,2'b00,1'b1,1'b0,2'b00,8'd0,1'b1, 2'b00,2'b00,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b00,2'b00,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b10,8'd2,1'b0, 2'b10,2'b00,2'b10,8'd2,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b10,2'b00,2'b10,8'd1,1'b0,1'b0);
      add(1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,8'd0,1'b1, 2'b10,2'b10,2'b00,8'd0,1'b0,1'b0);
      add(1'b1,1'b1,2'b01,1'b1,2'b11,1'b0,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b10,2'b01,8'd0,1'b1,1'b0);
      add(1'b1,1'b1,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,8'd0,1'b0, 2'b11,2'b11,2'b00,8'd0,1'b1,1'b0);

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst_n, tv[i].wr, tv[i].wd, tv[i].asg, tv[i].ad, tv[i].dasg,
               tv[i].frc, tv[i].fd, tv[i].fc, tv[i].rel);
         check_all(i, tv[i].eq, tv[i].eb, tv[i].es, tv[i].el, tv[i].ed, tv[i].ee);
      end

      for (int i = 0; i < 3000; i++) begin
         logic r, w, a, d, f, rl;
         logic [1:0] wd, ad, fd;
         logic [7:0] fc;
         r  = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
         w  = ($urandom_range(0, 1) == 0);
         a  = ($urandom_range(0, 5) == 0);
         d  = ($urandom_range(0, 5) == 0);
         f  = ($urandom_range(0, 7) == 0);
         rl = ($urandom_range(0, 5) == 0);
         wd = 2'($urandom_range(0, 3));
         ad = 2'($urandom_range(0, 3));
         fd = 2'($urandom_range(0, 3));
         fc = 8'($urandom_range(0, 6));
         model_step(r, w, wd, a, ad, d, f, fd, fc, rl);
         drive(r, w, wd, a, ad, d, f, fd, fc, rl);
         check_all(1000 + i, m_q, m_base, m_st, 8'(m_left), m_drop, m_err);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
